frame_downsampler: RTL and testbench
====================================

FRAME_DOWNSAMPLER -- requirements
Module: frame_downsampler

Interface
REQ-001 clk  input  1  single clock; all logic rising-edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 pix_valid  input  1  pix_data holds the next source pixel this cycle.
REQ-004 pix_data  input  12  source pixel {r[11:8], g[7:4], b[3:0]}, 640x480 raster order.
REQ-005 frame_start  input  1  one-cycle pulse marking source pixel (0,0); may coincide with pix_valid.
REQ-006 a_wr  output  1  write strobe to frame-buffer write port.
REQ-007 a_addr  output  17  frame-buffer word address, 0..76799.
REQ-008 a_din  output  12  downsampled pixel, same channel packing as pix_data.
REQ-009 frame_done  output  1  one-cycle pulse on the final write of a frame.
REQ-010 busy  output  1  high while in ACTIVE state.

Function
REQ-011 Shall downsample 640x480 to 320x240 by 2x2 box average, per 4-bit channel independently.
REQ-012 Output channel shall be (sum of four source channels) >> 2, truncating; 6-bit intermediate sum, no saturation needed.
REQ-013 Source counters x (0..639) and y (0..479) shall advance only on pix_valid cycles; arbitrary idle gaps between valid pixels are legal.
REQ-014 Even y, odd x: shall store horizontal pair sum (3 x 5 bits) of pixels (x-1,y),(x,y) into line buffer entry x>>1.
REQ-015 Odd y, even x: shall issue line-buffer read of entry x>>1; odd y, odd x: shall combine read data with current pair sum and write result.
REQ-016 a_wr shall be registered: high exactly one cycle, the cycle after the valid pixel at (odd x, odd y); a_addr/a_din valid in the same cycle.
REQ-017 a_addr shall be (y>>1)*320 + (x>>1), generated by an incrementing counter cleared on frame_start; no multiplier.
REQ-018 a_din/a_addr shall hold their last value when a_wr is low.
REQ-019 State machine: WAIT_SOF, ACTIVE.
REQ-020 WAIT_SOF -> ACTIVE on frame_start; pix_valid without frame_start in WAIT_SOF shall be ignored.
REQ-021 ACTIVE -> WAIT_SOF after pixel (639,479) is consumed; frame_done shall pulse with the write to address 76799.
REQ-022 frame_start in ACTIVE shall abandon the current frame: counters and address cleared, no further writes for old frame, stay ACTIVE; frame_done not pulsed.
REQ-023 frame_start with pix_valid in the same cycle shall treat that pixel as (0,0).
REQ-024 Exactly 76800 writes per uninterrupted frame, addresses strictly ascending 0..76799.
REQ-025 Write of the last pixel of a frame and frame_start for the next in the following cycle shall both be honoured.

Reset
REQ-026 reset_n low shall force WAIT_SOF, x=y=0, address counter=0, a_wr=0, a_addr=0, a_din=0, frame_done=0, busy=0.
REQ-027 Reset mid-frame shall discard partial frame; line-buffer contents need no reset.

Structure
REQ-028 Shared package shall hold SRC_W=640, SRC_H=480, DST_W=320, DST_H=240, PIX_W=12, ADDR_W=17, FRAME_WORDS=76800, CH_W=4.
REQ-029 One sub-module: fd_line_buffer, 320x15 single-clock memory, one write port, one synchronous read port (1-cycle latency), read data held between reads.
REQ-030 Frame-buffer port timing shall match the team's 12-bit 76800-word dual-port frame buffer write port (write on a_wr at rising clk).

Verification
REQ-031 frame_start then 307200 back-to-back pixels all 12'hFFF -> 76800 writes, a_din=12'hFFF, addrs 0..76799, frame_done once with addr 76799.
REQ-032 Rows 0/1 pixels (0,0)=12'h000,(1,0)=12'h111,(0,1)=12'h222,(1,1)=12'h333 -> first write addr 0, a_din=12'h111 (sum 6>>2=1).
REQ-033 Truncation: 2x2 block r-values 15,15,15,14 -> r out = 14.
REQ-034 Random 0-5 idle cycles between valid pixels, known gradient image -> write stream identical to gap-free run.
REQ-035 frame_start asserted at source pixel (100,200) -> no frame_done, next write addr 0 with new-frame data; 76800 writes follow.
REQ-036 reset_n pulsed low mid-frame -> outputs zero immediately; pixels ignored until next frame_start; pix_valid before frame_start produces no writes.

Source files
------------

// File: rtl/frame_downsampler_pkg.sv
// Shared geometry, pixel packing and channel arithmetic for the 2x2 frame downsampler.
package frame_downsampler_pkg;

    localparam int unsigned SRC_W       = 640;
    localparam int unsigned SRC_H       = 480;
    localparam int unsigned DST_W       = 320;
    localparam int unsigned DST_H       = 240;
    localparam int unsigned PIX_W       = 12;
    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned FRAME_WORDS = 76800;
    localparam int unsigned CH_W        = 4;

    localparam int unsigned SUM_W  = CH_W + 1;
    localparam int unsigned SUM2_W = CH_W + 2;
    localparam int unsigned PAIR_W = 3 * SUM_W;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } fd_state_e;

    typedef struct packed {
        logic [SUM_W-1:0] r;
        logic [SUM_W-1:0] g;
        logic [SUM_W-1:0] b;
    } pair_sum_t;

    // Per-channel sum of two horizontally adjacent source pixels.
    function automatic pair_sum_t pair_add(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        pair_sum_t s;
        s.r = SUM_W'(a[2*CH_W +: CH_W]) + SUM_W'(b[2*CH_W +: CH_W]);
        s.g = SUM_W'(a[CH_W +: CH_W])   + SUM_W'(b[CH_W +: CH_W]);
        s.b = SUM_W'(a[0 +: CH_W])      + SUM_W'(b[0 +: CH_W]);
        return s;
    endfunction

    // Combine upper and lower pair sums and divide by four, truncating.
    function automatic logic [PIX_W-1:0] box_avg(input pair_sum_t top, input pair_sum_t bot);
        logic [SUM2_W-1:0] sr;
        logic [SUM2_W-1:0] sg;
        logic [SUM2_W-1:0] sb;
        sr = SUM2_W'(top.r) + SUM2_W'(bot.r);
        sg = SUM2_W'(top.g) + SUM2_W'(bot.g);
        sb = SUM2_W'(top.b) + SUM2_W'(bot.b);
        return {sr[SUM2_W-1:2], sg[SUM2_W-1:2], sb[SUM2_W-1:2]};
    endfunction

endpackage

// File: rtl/fd_line_buffer.sv
// Single-clock line buffer holding even-row pair sums; synchronous read, data held between reads.
module fd_line_buffer
    import frame_downsampler_pkg::*;
#(
    parameter int unsigned DEPTH = DST_W,
    parameter int unsigned AW    = $clog2(DST_W),
    parameter int unsigned DW    = PAIR_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Storage carries no reset: every entry is rewritten on an even row before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_downsampler.sv
// 2x2 box-average downsampler streaming source raster pixels into a frame-buffer write port.
module frame_downsampler
    import frame_downsampler_pkg::*;
#(
    parameter int unsigned IMG_W = SRC_W,
    parameter int unsigned IMG_H = SRC_H
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              frame_start,
    output logic              a_wr,
    output logic [ADDR_W-1:0] a_addr,
    output logic [PIX_W-1:0]  a_din,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned X_W      = $clog2(IMG_W);
    localparam int unsigned Y_W      = $clog2(IMG_H);
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LB_AW    = $clog2(LB_DEPTH);

    fd_state_e         state_q, state_d;
    logic [X_W-1:0]    x_q, x_d, cur_x;
    logic [Y_W-1:0]    y_q, y_d, cur_y;
    logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
    logic [PIX_W-1:0]  prev_q, prev_d;
    logic              a_wr_q, a_wr_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [PIX_W-1:0]  a_din_q, a_din_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;

    logic              take;
    pair_sum_t         pair_sum;
    pair_sum_t         lb_rd_data;
    logic              lb_wr;
    logic              lb_rd;
    logic [LB_AW-1:0]  lb_addr;

    // frame_start restarts the raster, so the pixel arriving with it is (0,0).
    always_comb begin
        cur_x    = frame_start ? '0 : x_q;
        cur_y    = frame_start ? '0 : y_q;
        cur_addr = frame_start ? '0 : addr_q;
        take     = pix_valid && (frame_start || (state_q == ACTIVE));
        pair_sum = pair_add(prev_q, pix_data);
        lb_addr  = LB_AW'(cur_x >> 1);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        prev_d       = prev_q;
        a_wr_d       = 1'b0;
        a_addr_d     = a_addr_q;
        a_din_d      = a_din_q;
        frame_done_d = 1'b0;
        lb_wr        = 1'b0;
        lb_rd        = 1'b0;

        if (frame_start) begin
            state_d = ACTIVE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
        end

        if (take) begin
            if (!cur_x[0]) begin
                prev_d = pix_data;
                lb_rd  = cur_y[0];
            end else if (!cur_y[0]) begin
                lb_wr = 1'b1;
            end else begin
                a_wr_d   = 1'b1;
                a_addr_d = cur_addr;
                a_din_d  = box_avg(lb_rd_data, pair_sum);
                addr_d   = cur_addr + ADDR_W'(1);
            end

            // Raster advance; the final pixel closes the frame and returns to WAIT_SOF.
            if (cur_x == X_W'(IMG_W - 1)) begin
                x_d = '0;
                if (cur_y == Y_W'(IMG_H - 1)) begin
                    y_d          = '0;
                    addr_d       = '0;
                    state_d      = WAIT_SOF;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = cur_y + Y_W'(1);
                end
            end else begin
                x_d = cur_x + X_W'(1);
            end
        end

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            prev_q       <= '0;
            a_wr_q       <= 1'b0;
            a_addr_q     <= '0;
            a_din_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            prev_q       <= prev_d;
            a_wr_q       <= a_wr_d;
            a_addr_q     <= a_addr_d;
            a_din_q      <= a_din_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    fd_line_buffer #(
        .DEPTH (LB_DEPTH),
        .AW    (LB_AW),
        .DW    (PAIR_W)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data (pair_sum),
        .rd_en   (lb_rd),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_data)
    );

    assign a_wr       = a_wr_q;
    assign a_addr     = a_addr_q;
    assign a_din      = a_din_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_downsampler.sv
// Directed bench for frame_downsampler on a reduced 16x8 raster (8x4 output, 32 writes per frame).
module tb_frame_downsampler;

    localparam int unsigned W      = 16;
    localparam int unsigned H      = 8;
    localparam int unsigned DW_O   = W / 2;
    localparam int unsigned NWORDS = (W / 2) * (H / 2);

    logic        clk;
    logic        reset_n;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        frame_start;
    logic        a_wr;
    logic [16:0] a_addr;
    logic [11:0] a_din;
    logic        frame_done;
    logic        busy;

    frame_downsampler #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .frame_start (frame_start),
        .a_wr        (a_wr),
        .a_addr      (a_addr),
        .a_din       (a_din),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] img [H][W];
    logic [16:0] got_addr[$];
    logic [11:0] got_din[$];
    logic        got_done[$];
    logic [16:0] exp_addr[$];
    logic [11:0] exp_din[$];
    logic        exp_done[$];
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_wr) begin
            got_addr.push_back(a_addr);
            got_din.push_back(a_din);
            got_done.push_back(frame_done);
        end
        if (frame_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flat(input logic [11:0] v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = v;
    endtask

    // Gradient image with the first two blocks replaced by hand-worked values.
    task automatic set_gradient();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = 12'(x * 37 + y * 91 + x * y * 5);
        img[0][0] = 12'h000; img[0][1] = 12'h111;
        img[1][0] = 12'h222; img[1][1] = 12'h333;
        img[0][2] = 12'hF00; img[0][3] = 12'hF00;
        img[1][2] = 12'hF00; img[1][3] = 12'hE00;
    endtask

    function automatic logic [11:0] box(input int bx, input int by);
        logic [11:0] r;
        for (int c = 0; c < 3; c++) begin
            int s;
            s = 0;
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++)
                    s += int'((img[2*by+dy][2*bx+dx] >> (4*c)) & 12'hF);
            r[4*c +: 4] = 4'(s / 4);
        end
        return r;
    endfunction

    task automatic build_expect(input int nblocks);
        for (int k = 0; k < nblocks; k++) begin
            exp_addr.push_back(17'(k));
            exp_din.push_back(box(k % DW_O, k / DW_O));
            exp_done.push_back((nblocks == NWORDS) && (k == NWORDS - 1));
        end
    endtask

    task automatic drive_frame(input int max_gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            pix_valid   = 1'b1;
            pix_data    = img[i / W][i % W];
            frame_start = (i == 0);
            tick();
            pix_valid   = 1'b0;
            frame_start = 1'b0;
            if (i != npix - 1) begin
                int g;
                g = int'($urandom_range(0, max_gap));
                repeat (g) tick();
            end
        end
    endtask

    initial begin
        int n_before;
        int d_before;
        int n;
        reset_n     = 1'b0;
        pix_valid   = 1'b0;
        pix_data    = '0;
        frame_start = 1'b0;
        repeat (3) tick();
        check("rst_wr",   32'(a_wr), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_din",  32'(a_din), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Two frames back to back: gradient then all-white.
        set_gradient();
        build_expect(NWORDS);
        drive_frame(0, W * H);
        set_flat(12'hFFF);
        build_expect(NWORDS);
        drive_frame(0, W * H);
        repeat (3) tick();
        check("b2b_done_cnt", 32'(done_cnt), 2);
        check("idle_busy", 32'(busy), 0);

        // Same gradient with random idle gaps.
        set_gradient();
        build_expect(NWORDS);
        drive_frame(5, W * H);
        repeat (3) tick();
        check("gap_done_cnt", 32'(done_cnt), 3);

        // Abandon after pixel (4,3): 8 writes from row pair 0, 2 from row pair 1.
        d_before = done_cnt;
        set_flat(12'h5A5);
        build_expect(10);
        drive_frame(0, 3 * W + 5);
        check("abandon_busy", 32'(busy), 1);
        check("abandon_no_done", 32'(done_cnt), 32'(d_before));
        set_gradient();
        build_expect(NWORDS);
        drive_frame(0, W * H);
        repeat (3) tick();
        check("abandon_done_cnt", 32'(done_cnt), 32'(d_before + 1));

        // Reset mid-frame right after the write from pixel (3,1).
        set_flat(12'h777);
        build_expect(2);
        drive_frame(0, W + 4);
        @(negedge clk);
        #1;
        check("pre_rst_wr",   32'(a_wr), 1);
        check("pre_rst_addr", 32'(a_addr), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wr",   32'(a_wr), 0);
        check("mid_rst_addr", 32'(a_addr), 0);
        check("mid_rst_din",  32'(a_din), 0);
        check("mid_rst_busy", 32'(busy), 0);
        tick();
        reset_n = 1'b1;
        tick();
        n_before = got_addr.size();
        for (int i = 0; i < 40; i++) begin
            pix_valid = 1'b1;
            pix_data  = 12'($urandom);
            tick();
        end
        pix_valid = 1'b0;
        repeat (2) tick();
        check("no_sof_writes", 32'(got_addr.size()), 32'(n_before));
        check("no_sof_busy", 32'(busy), 0);
        set_gradient();
        build_expect(NWORDS);
        drive_frame(2, W * H);
        repeat (3) tick();
        check("final_done_cnt", 32'(done_cnt), 5);

        // Whole captured write stream against the expected stream.
        check("n_writes", 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("addr[%0d]", i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check($sformatf("din[%0d]", i),  32'(got_din[i]),  32'(exp_din[i]));
            check($sformatf("done[%0d]", i), 32'(got_done[i]), 32'(exp_done[i]));
        end
        if (n >= 64) begin
            check("first_blk_111", 32'(got_din[0]), 32'h111);
            check("trunc_r14",     32'(got_din[1]), 32'hE00);
            check("last_addr",     32'(got_addr[NWORDS-1]), 32'(NWORDS - 1));
            check("white_din",     32'(got_din[NWORDS + 5]), 32'hFFF);
        end else begin
            check("stream_len", 32'(n), 64);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
